// File: rtl/bcd_pkg.sv
// Shared BCD types, digit constants and the digit legality helper used by
// the N-digit up/down counter and its per-digit slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam bcd_digit_t BCD_ZERO      = 4'd0;

  // A nibble is a legal BCD digit when it lies in 0..9.
  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter. Holds a single digit, applies clear, load
// and a single up/down step, and reports whether it sits at the limit for
// the current direction so the parent can ripple the step upward.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  bcd_digit_t rst_val,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step,
  input  logic       up_dn,
  output bcd_digit_t digit,
  output logic       at_limit
);

  // At the limit means the next step in this direction wraps the digit.
  assign at_limit = up_dn ? (digit == BCD_MAX_DIGIT) : (digit == BCD_ZERO);

  // Digit register: clear beats load beats step; a wrapping step rolls 9->0 or 0->9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= rst_val;
    end else if (clear) begin
      digit <= rst_val;
    end else if (load) begin
      digit <= load_digit;
    end else if (step) begin
      if (up_dn) begin
        digit <= (digit == BCD_MAX_DIGIT) ? BCD_ZERO : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_ZERO) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_ctr.sv
// Parametrised N-digit BCD up/down counter with synchronous clear, checked
// parallel load and a combinational terminal-count output for cascading.
// Optional build macro BCD_CTR_SATURATE_EN: when defined, the counter holds
// at 99..9 going up and at 0 going down instead of wrapping.
module bcd_updown_ctr
  import bcd_pkg::*;
#(
  parameter int                        NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0]   RST_VAL    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    count_en,
  input  logic                    up_dn,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    tc,
  output logic                    load_err
);

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("bcd_updown_ctr: NUM_DIGITS must be in 1..8");
  end

  logic [NUM_DIGITS-1:0] digit_legal;
  logic [NUM_DIGITS-1:0] at_limit;
  logic [NUM_DIGITS-1:0] step_chain;
  logic                  load_ok;
  logic                  load_accept;
  logic                  all_at_limit;
  logic                  count_step;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    if (!is_bcd_digit(RST_VAL[4*g +: 4])) begin : g_bad_rst_val
      $error("bcd_updown_ctr: RST_VAL contains a non-BCD digit");
    end

    assign digit_legal[g] = is_bcd_digit(load_val[4*g +: 4]);

    // A digit steps only when every lower digit is about to wrap.
    if (g > 0) begin : g_ripple
      assign step_chain[g] = step_chain[g-1] & at_limit[g-1];
    end

    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .rst_val    (RST_VAL[4*g +: 4]),
      .clear      (clear),
      .load       (load_accept),
      .load_digit (load_val[4*g +: 4]),
      .step       (step_chain[g]),
      .up_dn      (up_dn),
      .digit      (bcd[4*g +: 4]),
      .at_limit   (at_limit[g])
    );
  end

  assign all_at_limit = &at_limit;
  assign tc           = count_en & all_at_limit;

`ifdef BCD_CTR_SATURATE_EN
  assign count_step = count_en & ~all_at_limit;
`else
  assign count_step = count_en;
`endif

  // A load request, accepted or rejected, suppresses counting in that cycle.
  assign step_chain[0] = count_step & ~clear & ~load;

  assign load_ok     = &digit_legal;
  assign load_accept = load & load_ok;

  // Rejected-load flag is a one-cycle pulse, cleared by reset and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else if (clear) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_updown_ctr.sv
// Scoreboard bench for bcd_updown_ctr (two digits). The stimulus side keeps
// a decimal integer model of the count and queues expected results; a
// separate monitor checks tc before each edge and bcd/load_err after it.
module tb_bcd_updown_ctr;
  import bcd_pkg::*;

  localparam int              N    = 2;
  localparam int              W    = 4 * N;
  localparam int              MAXV = 100;
  localparam logic [W-1:0]    RV   = 8'h00;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         count_en;
  logic         up_dn;
  logic [W-1:0] bcd;
  logic         tc;
  logic         load_err;

  typedef struct {
    logic [W-1:0] bcd;
    logic         err;
    logic         tc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   model_v;

  bcd_updown_ctr #(.NUM_DIGITS(N), .RST_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count_en (count_en),
    .up_dn    (up_dn),
    .bcd      (bcd),
    .tc       (tc),
    .load_err (load_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Decimal integer to packed BCD.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Packed BCD to decimal integer (caller guarantees legality).
  function automatic int from_bcd(input logic [W-1:0] x);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      v = v + int'(x[4*i +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic bit all_legal(input logic [W-1:0] x);
    for (int i = 0; i < N; i++) begin
      if (x[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One comparison: counts it, reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the decimal model and queues the
  // expected tc (before the edge) and bcd/load_err (after the edge).
  task automatic applyStimulus(input logic c, input logic l, input logic [W-1:0] lv,
                               input logic en, input logic ud);
    exp_t e;
    clear    = c;
    load     = l;
    load_val = lv;
    count_en = en;
    up_dn    = ud;
    e.tc  = en && (ud ? (model_v == MAXV - 1) : (model_v == 0));
    e.err = 1'b0;
    if (c) begin
      model_v = from_bcd(RV);
    end else if (l) begin
      if (all_legal(lv)) model_v = from_bcd(lv);
      else               e.err = 1'b1;
    end else if (en) begin
`ifdef BCD_CTR_SATURATE_EN
      if (ud) model_v = (model_v == MAXV - 1) ? model_v : model_v + 1;
      else    model_v = (model_v == 0) ? 0 : model_v - 1;
`else
      if (ud) model_v = (model_v + 1) % MAXV;
      else    model_v = (model_v + MAXV - 1) % MAXV;
`endif
    end
    e.bcd = to_bcd(model_v);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: tc is checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput("tc", 32'(tc), 32'(sb[0].tc));
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("bcd", 32'(bcd), 32'(e.bcd));
        checkOutput("load_err", 32'(load_err), 32'(e.err));
      end
    end
  end

  // Directed scenarios followed by a random mix, then the summary.
  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    count_en = 1'b0;
    up_dn    = 1'b1;
    model_v  = from_bcd(RV);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_bcd", 32'(bcd), 32'(RV));
    checkOutput("reset_err", 32'(load_err), 32'd0);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-count at 37.
    applyStimulus(1'b0, 1'b1, 8'h36, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_bcd", 32'(bcd), 32'(RV));
    checkOutput("async_rst_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    model_v = from_bcd(RV);

    // Full up sweep 00..99 and wrap back to 00.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 101; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Down from 00 wraps to 99; down from 10 gives 09.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Rejected loads hold the count and pulse load_err; a legal load follows.
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h59, 1'b0, 1'b1);

    // Clear wins over load and count; load wins over count.
    applyStimulus(1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h27, 1'b1, 1'b1);

    // Three up steps from 99: wraps by default, holds when saturating.
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random mix of all controls, including illegal load values.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 7) == 0),
                    W'($urandom),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
